mul_div_seq: RTL and testbench

Sequential multi-cycle multiply/divide unit that executes the MUL (FS = 5'h1E) and DIV (FS = 5'h1F) function-select codes, which the combinational ALU reserves but does not compute. It sits beside the ALU in the execute stage. It accepts an operation through a start/busy/done handshake and writes a 64-bit result split into Y_hi and Y_lo, in the same layout the HI/LO registers consume. Both operations are signed, 32-bit, radix-2, one iteration per clock.

---
 rtl/mul_div_seq.sv | 199 +++++++++++++++++++
 tb/tb_mul_div_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_seq.sv
// ============================================================================
// Module   : mul_div_seq
// Purpose  : Signed 32-bit sequential multiply (FS=1E) / divide (FS=1F) unit,
//            radix-2, one iteration per clock, 64-bit result as Y_hi/Y_lo.
//            Divider compiled in only when MULDIV_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  FS,
    input  logic [31:0] S,
    input  logic [31:0] T,
    output logic        busy,
    output logic        done,
    output logic [31:0] Y_hi,
    output logic [31:0] Y_lo,
    output logic        V
);

    localparam logic [4:0] c_FS_MUL = 5'h1E;
`ifdef MULDIV_DIV_EN
    localparam logic [4:0] c_FS_DIV = 5'h1F;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [5:0]  count_q, count_d;
    logic        s_neg_q, s_neg_d;
    logic        t_neg_q, t_neg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] y_hi_q, y_hi_d;
    logic [31:0] y_lo_q, y_lo_d;
    logic        v_q, v_d;
`ifdef MULDIV_DIV_EN
    logic        is_div_q, is_div_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;
    logic [32:0] w_rsh;
    logic [32:0] w_diff;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
`endif

    logic [31:0] w_s_mag;
    logic [31:0] w_t_mag;
    logic        w_supported;
    logic [63:0] w_prod;

    always_comb begin
        w_s_mag     = S[31] ? (~S + 32'd1) : S;
        w_t_mag     = T[31] ? (~T + 32'd1) : T;
        w_supported = (FS == c_FS_MUL);
`ifdef MULDIV_DIV_EN
        w_supported = w_supported || (FS == c_FS_DIV);
        is_div_d    = is_div_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        // Remainder < divisor <= 2^31, so the shifted partial remainder fits 33 bits.
        w_rsh       = {acc_q[63:32], a_q[31]};
        w_diff      = w_rsh - {1'b0, b_q};
        w_quot      = (s_neg_q ^ t_neg_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        w_rem       = s_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
`endif
        w_prod      = (s_neg_q ^ t_neg_q) ? (~acc_q + 64'd1) : acc_q;

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        count_d = count_q;
        s_neg_d = s_neg_q;
        t_neg_d = t_neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        y_hi_d  = y_hi_q;
        y_lo_d  = y_lo_q;
        v_d     = v_q;

        case (state_q)
            CALC: begin
                if (count_q != 6'd32) begin
                    count_d = count_q + 6'd1;
                    a_d     = a_q << 1;
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        if (!w_diff[32]) begin
                            acc_d = {w_diff[31:0], acc_q[30:0], 1'b1};
                        end else begin
                            acc_d = {w_rsh[31:0], acc_q[30:0], 1'b0};
                        end
                    end else
`endif
                    begin
                        acc_d = acc_q + (b_q[0] ? a_q : 64'd0);
                        b_d   = b_q >> 1;
                    end
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        // Divide-by-zero leaves |S| as remainder, so Y_hi = S falls out naturally.
                        y_hi_d = w_rem;
                        y_lo_d = dz_q ? 32'hFFFF_FFFF : w_quot;
                        v_d    = dz_q | ovf_q;
                    end else
`endif
                    begin
                        y_hi_d = w_prod[63:32];
                        y_lo_d = w_prod[31:0];
                        v_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (start && w_supported) begin
                    state_d = CALC;
                    busy_d  = 1'b1;
                    a_d     = {32'd0, w_s_mag};
                    b_d     = w_t_mag;
                    acc_d   = 64'd0;
                    count_d = 6'd0;
                    s_neg_d = S[31];
                    t_neg_d = T[31];
`ifdef MULDIV_DIV_EN
                    is_div_d = (FS == c_FS_DIV);
                    dz_d     = (T == 32'd0);
                    ovf_d    = (S == 32'h8000_0000) && (T == 32'hFFFF_FFFF);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            a_q      <= 64'd0;
            b_q      <= 32'd0;
            acc_q    <= 64'd0;
            count_q  <= 6'd0;
            s_neg_q  <= 1'b0;
            t_neg_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            y_hi_q   <= 32'd0;
            y_lo_q   <= 32'd0;
            v_q      <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            s_neg_q  <= s_neg_d;
            t_neg_q  <= t_neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            y_hi_q   <= y_hi_d;
            y_lo_q   <= y_lo_d;
            v_q      <= v_d;
`ifdef MULDIV_DIV_EN
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Y_hi = y_hi_q;
    assign Y_lo = y_lo_q;
    assign V    = v_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_seq.sv
// ============================================================================
// Module   : tb_mul_div_seq
// Purpose  : Scoreboard bench for mul_div_seq against a signed-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  FS;
    logic [31:0] S;
    logic [31:0] T;
    logic        busy;
    logic        done;
    logic [31:0] Y_hi;
    logic [31:0] Y_lo;
    logic        V;

    mul_div_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .FS    (FS),
        .S     (S),
        .T     (T),
        .busy  (busy),
        .done  (done),
        .Y_hi  (Y_hi),
        .Y_lo  (Y_lo),
        .V     (V)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        v;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;
    logic        last_v  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
        exp_t   e;
        longint a;
        longint b;
        longint r;
        a = longint'($signed(s));
        b = longint'($signed(t));
        e.cyc = 0;
        if (fs == 5'h1E) begin
            r    = a * b;
            e.hi = r[63:32];
            e.lo = r[31:0];
            e.v  = 1'b0;
        end else if (t == 32'd0) begin
            e.hi = s;
            e.lo = 32'hFFFF_FFFF;
            e.v  = 1'b1;
        end else if (s == 32'h8000_0000 && t == 32'hFFFF_FFFF) begin
            e.hi = 32'd0;
            e.lo = 32'h8000_0000;
            e.v  = 1'b1;
        end else begin
            r    = a / b;
            e.lo = r[31:0];
            r    = a % b;
            e.hi = r[31:0];
            e.v  = 1'b0;
        end
        return e;
    endfunction

    function automatic bit supported(input logic [4:0] fs);
`ifdef MULDIV_DIV_EN
        return (fs == 5'h1E) || (fs == 5'h1F);
`else
        return (fs == 5'h1E);
`endif
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            chk("busy_done_exclusive", {63'd0, busy}, 64'd0);
            if (sbq.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("Y_hi", {32'd0, Y_hi}, {32'd0, e.hi});
                chk("Y_lo", {32'd0, Y_lo}, {32'd0, e.lo});
                chk("V", {63'd0, V}, {63'd0, e.v});
                chk("latency", 64'(cyc), 64'(e.cyc));
                last_hi = e.hi;
                last_lo = e.lo;
                last_v  = e.v;
            end
        end
    end

    task automatic issue(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
        int   n;
        exp_t e;
        bit   saw_busy;
        bit   saw_done;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("wait_idle_timeout", 64'd1, 64'd0);
        start = 1'b1;
        FS    = fs;
        S     = s;
        T     = t;
        @(posedge clk);
        #1;
        start = 1'b0;
        FS    = 5'($urandom);
        S     = $urandom;
        T     = $urandom;
        if (supported(fs)) begin
            e     = model(fs, s, t);
            e.cyc = cyc + 33;
            sbq.push_back(e);
            chk("accept_busy", {63'd0, busy}, 64'd1);
        end else begin
            saw_busy = busy;
            saw_done = done;
            repeat (40) begin
                @(negedge clk);
                saw_busy |= busy;
                saw_done |= done;
            end
            chk("unsup_busy", {63'd0, saw_busy}, 64'd0);
            chk("unsup_done", {63'd0, saw_done}, 64'd0);
            chk("unsup_Y_hi", {32'd0, Y_hi}, {32'd0, last_hi});
            chk("unsup_Y_lo", {32'd0, Y_lo}, {32'd0, last_lo});
            chk("unsup_V", {63'd0, V}, {63'd0, last_v});
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        FS    = 5'd0;
        S     = 32'd0;
        T     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_Y", {Y_hi, Y_lo}, 64'd0);
        chk("rst_V", {63'd0, V}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        issue(5'h1E, 32'hFFFF_FFFF, 32'h0000_0002);
        issue(5'h1E, 32'h8000_0000, 32'h8000_0000);
        // A start while busy must be dropped with no extra done.
        repeat (5) @(negedge clk);
        start = 1'b1;
        FS    = 5'h1E;
        S     = 32'd7;
        T     = 32'd9;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ignored", {63'd0, busy}, 64'd1);

        issue(5'h1F, 32'hFFFF_FFF9, 32'd2);
        issue(5'h1F, 32'd5, 32'd0);
        issue(5'h1F, 32'h8000_0000, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of a multiply.
        issue(5'h1E, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_Y", {Y_hi, Y_lo}, 64'd0);
        chk("midrst_V", {63'd0, V}, 64'd0);
        sbq.delete();
        last_hi = 32'd0;
        last_lo = 32'd0;
        last_v  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        issue(5'h1E, 32'd3, 32'd4);

        issue(5'h02, 32'd11, 32'd13);
        issue(5'h1F, 32'd100, 32'd7);

        for (int i = 0; i < 24; i++) begin
            issue($urandom_range(0, 1) ? 5'h1E : 5'h1F, pick(), pick());
        end

        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
